// File: rtl/multicycle_controller_pkg.sv
// rv32i_pkg: shared types and constants for the multi-cycle RV32I controller.
//   - opcode constants for the supported instruction classes
//   - mux-select, ALU-control, FSM-state and trap-cause enums
//   - classify(): maps a raw opcode onto an instruction class
package rv32i_pkg;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_SRA  = 4'b1101
  } alu_ctrl_t;

  typedef enum logic [2:0] {IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010} imm_sel_t;
  typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10} alu_src_a_t;
  typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_t;
  typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10} result_src_t;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00, CAUSE_ILLEGAL = 2'b01, CAUSE_TIMEOUT = 2'b10
  } trap_cause_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
  } op_class_t;

  function automatic op_class_t classify(input logic [6:0] opc);
    case (opc)
      OPC_R:      return CLS_R;
      OPC_I:      return CLS_I;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Shared memory-port handshake between the controller and the memory.
//   mem_re / mem_we : read / write request (controller -> memory)
//   addr_src        : address mux select, 0 = PC, 1 = alu_out register
//   mem_ready       : memory completes the current request this cycle
interface multicycle_controller_if;
  logic mem_re;
  logic mem_we;
  logic addr_src;
  logic mem_ready;

  modport master (output mem_re, output mem_we, output addr_src, input mem_ready);
  modport slave  (input mem_re, input mem_we, input addr_src, output mem_ready);
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: combinational ALU-operation decode and funct legality.
//   op_class    : instruction class from the opcode
//   funct3/7    : instruction function fields
//   alu_control : {funct7[5],funct3}-style ALU operation
//   legal       : instruction is a supported encoding
module alu_decoder
  import rv32i_pkg::*;
#(
  parameter int BRANCH_FULL = 1
) (
  input  op_class_t   op_class,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [3:0]  alu_control,
  output logic        legal
);

  always_comb begin
    alu_control = ALU_ADD;
    legal       = 1'b1;
    case (op_class)
      CLS_R: begin
        alu_control = {funct7[5], funct3};
        if (funct7 == 7'b0100000) legal = (funct3 == 3'b000) || (funct3 == 3'b101);
        else                      legal = (funct7 == 7'b0000000);
      end
      // Only SRAI carries an alternate-op bit in the immediate
      CLS_I:      alu_control = {funct7[5] && (funct3 == 3'b101), funct3};
      CLS_LOAD,
      CLS_STORE:  alu_control = ALU_ADD;
      CLS_BRANCH: begin
        alu_control = ALU_SUB;
        legal = (BRANCH_FULL != 0) ? (funct3[2:1] != 2'b01) : (funct3[2:1] == 2'b00);
      end
      default:    legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer
// for a multi-cycle RV32I datapath, with illegal-instruction and memory
// timeout traps.
//   clk, rst          : clock (rising edge), async active-low reset
//   mem               : memory handshake (mem_re, mem_we, addr_src, mem_ready)
//   opcode/funct3/7   : instruction register fields
//   alu_zero/lt/ltu   : ALU compare flags for rs1-rs2
//   ir_write, pc_write, regwrite, alu_src_a/b, result_src, alu_control,
//   imm_sel           : datapath controls
//   instr_done        : one-cycle retire pulse
//   trap, trap_cause  : sticky trap flag and its cause
module multicycle_controller
  import rv32i_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int BRANCH_FULL = 1,
  parameter int TIMER_W     = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic       clk,
  input  logic       rst,
  multicycle_controller_if.master mem,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       alu_zero,
  input  logic       alu_lt,
  input  logic       alu_ltu,
  output logic       ir_write,
  output logic       pc_write,
  output logic       regwrite,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [3:0] alu_control,
  output logic [2:0] imm_sel,
  output logic       instr_done,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam int CNT_W = (TIMER_W < 1) ? 1 : TIMER_W;
  localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  trap_cause_t       cause_q, cause_d;

  op_class_t   op_class;
  logic [3:0]  dec_alu;
  logic        dec_legal;
  logic        taken;
  logic        timeout_hit;
  logic        is_load;

  assign op_class = classify(opcode);
  assign is_load  = (op_class == CLS_LOAD);

  alu_decoder #(.BRANCH_FULL(BRANCH_FULL)) u_alu_decoder (
    .op_class    (op_class),
    .funct3      (funct3),
    .funct7      (funct7),
    .alu_control (dec_alu),
    .legal       (dec_legal)
  );

  always_comb begin
    case (funct3)
      3'b000:  taken = alu_zero;
      3'b001:  taken = !alu_zero;
      3'b100:  taken = alu_lt;
      3'b101:  taken = !alu_lt;
      3'b110:  taken = alu_ltu;
      3'b111:  taken = !alu_ltu;
      default: taken = 1'b0;
    endcase
  end

  // A ready in the limit cycle still completes normally
  assign timeout_hit = (MEM_TIMEOUT != 0) && (cnt_q == TMO_VAL) && !mem.mem_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    cause_d      = cause_q;
    mem.mem_re   = 1'b0;
    mem.mem_we   = 1'b0;
    mem.addr_src = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    regwrite     = 1'b0;
    alu_src_a    = SRCA_PC;
    alu_src_b    = SRCB_RS2;
    result_src   = RES_ALUOUT;
    alu_control  = ALU_ADD;
    imm_sel      = IMM_I;
    instr_done   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem.mem_re = 1'b1;
        alu_src_b  = SRCB_FOUR;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_sel   = IMM_B;
        if (!dec_legal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_control = dec_alu;
        alu_src_a   = SRCA_RS1;
        case (op_class)
          CLS_R:     state_d = S_WRITEBACK;
          CLS_I:     begin alu_src_b = SRCB_IMM; state_d = S_WRITEBACK; end
          CLS_LOAD:  begin alu_src_b = SRCB_IMM; state_d = S_MEMORY; end
          CLS_STORE: begin alu_src_b = SRCB_IMM; imm_sel = IMM_S; state_d = S_MEMORY; end
          CLS_BRANCH: begin
            pc_write   = taken;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: begin
            state_d = S_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMORY: begin
        mem.addr_src = 1'b1;
        mem.mem_re   = is_load;
        mem.mem_we   = !is_load;
        if (mem.mem_ready) begin
          if (is_load) begin
            state_d = S_WRITEBACK;
          end else begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITEBACK: begin
        regwrite   = 1'b1;
        result_src = is_load ? RES_MEM : RES_ALUOUT;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase

    trap       = (state_q == S_TRAP);
    trap_cause = cause_q;

    // Reset is asynchronous, so gate every output while it is held
    if (!rst) begin
      mem.mem_re   = 1'b0;
      mem.mem_we   = 1'b0;
      mem.addr_src = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      regwrite     = 1'b0;
      alu_src_a    = '0;
      alu_src_b    = '0;
      result_src   = '0;
      alu_control  = '0;
      imm_sel      = '0;
      instr_done   = 1'b0;
      trap         = 1'b0;
      trap_cause   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= CAUSE_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller. Two instances share stimulus:
// dut0 (MEM_TIMEOUT=16, BRANCH_FULL=1) and dut1 (MEM_TIMEOUT=4,
// BRANCH_FULL=0); `sel` chooses which one is checked. The reference model
// walks each instruction as a list of phases with per-phase expected controls.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic       alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;

  logic       irw0, pcw0, rw0, done0, trap0, irw1, pcw1, rw1, done1, trap1;
  logic [1:0] asa0, asb0, rs0, cause0, asa1, asb1, rs1, cause1;
  logic [3:0] alu0, alu1;
  logic [2:0] imm0, imm1;

  multicycle_controller_if mif0 ();
  multicycle_controller_if mif1 ();

  multicycle_controller #(.MEM_TIMEOUT(16), .BRANCH_FULL(1)) dut0 (
    .clk(clk), .rst(rst), .mem(mif0.master),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .ir_write(irw0), .pc_write(pcw0), .regwrite(rw0),
    .alu_src_a(asa0), .alu_src_b(asb0), .result_src(rs0),
    .alu_control(alu0), .imm_sel(imm0), .instr_done(done0),
    .trap(trap0), .trap_cause(cause0)
  );

  multicycle_controller #(.MEM_TIMEOUT(4), .BRANCH_FULL(0)) dut1 (
    .clk(clk), .rst(rst), .mem(mif1.master),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
    .ir_write(irw1), .pc_write(pcw1), .regwrite(rw1),
    .alu_src_a(asa1), .alu_src_b(asb1), .result_src(rs1),
    .alu_control(alu1), .imm_sel(imm1), .instr_done(done1),
    .trap(trap1), .trap_cause(cause1)
  );

  int sel = 0;
  logic [7:0] o_ctrl;
  logic [1:0] o_asa, o_asb, o_rs, o_cause;
  logic [3:0] o_alu;
  logic [2:0] o_imm;

  always_comb begin
    if (sel == 0) begin
      o_ctrl = {mif0.mem_re, mif0.mem_we, mif0.addr_src, irw0, pcw0, rw0, done0, trap0};
      o_asa = asa0; o_asb = asb0; o_rs = rs0; o_cause = cause0; o_alu = alu0; o_imm = imm0;
    end else begin
      o_ctrl = {mif1.mem_re, mif1.mem_we, mif1.addr_src, irw1, pcw1, rw1, done1, trap1};
      o_asa = asa1; o_asb = asb1; o_rs = rs1; o_cause = cause1; o_alu = alu1; o_imm = imm1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", tag, got, exp, $time, sel);
    end
  endtask

  // {mem_re, mem_we, addr_src, ir_write, pc_write, regwrite, instr_done, trap}
  function automatic logic [7:0] ctl(input bit re, we, as, ir, pcw, rw, dn, tr);
    return {re, we, as, ir, pcw, rw, dn, tr};
  endfunction

  function automatic bit m_legal(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [6:0] f7, input bit bfull);
    case (op)
      7'h33:               return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      7'h13, 7'h03, 7'h23: return 1'b1;
      7'h63:               return bfull ? !(f3 == 3'd2 || f3 == 3'd3) : (f3 <= 3'd1);
      default:             return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    case (op)
      7'h33:   return {f7[5], f3};
      7'h13:   return (f3 == 3'd5) ? {f7[5], f3} : {1'b0, f3};
      7'h63:   return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic bit m_taken(input logic [2:0] f3, input bit z, lt, ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_cycles(input logic [6:0] op, input int fw, input int mw);
    case (op)
      7'h03:   return 5 + fw + mw;
      7'h23:   return 4 + fw + mw;
      7'h63:   return 3 + fw;
      default: return 4 + fw;
    endcase
  endfunction

  task automatic drive_ready(input logic r);
    mif0.mem_ready = r;
    mif1.mem_ready = r;
  endtask

  // Called just after a falling edge; returns just after a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    drive_ready(1'b1);
    #1;
    check("reset.ctrl", o_ctrl, 8'h00);
    check("reset.cause", o_cause, 2'b00);
    check("reset.srcs", {o_asa, o_asb, o_alu}, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic expect_trap(input logic [1:0] cause);
    for (int i = 0; i < 2; i++) begin
      drive_ready(1'($urandom_range(0, 1)));
      #1;
      check("trap.ctrl", o_ctrl, ctl(0, 0, 0, 0, 0, 0, 0, 1));
      check("trap.cause", o_cause, cause);
      @(negedge clk);
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input bit z, input bit lt, input bit ltu,
                           input int fw, input int mw, input bit abort_mem, output bit stopped);
    int  tmo;
    bit  bfull, ld, st, br, tk, r;
    int  cyc;
    tmo   = (sel == 0) ? 16 : 4;
    bfull = (sel == 0);
    ld = (op == 7'h03); st = (op == 7'h23); br = (op == 7'h63);
    cyc = 0;
    stopped = 1'b0;
    opcode = op; funct3 = f3; funct7 = f7;
    alu_zero = z; alu_lt = lt; alu_ltu = ltu;

    for (int k = 0; k < 100; k++) begin
      r = (k >= fw);
      drive_ready(r);
      #1; cyc++;
      check("fetch.ctrl", o_ctrl, ctl(1, 0, 0, r, r, 0, 0, 0));
      check("fetch.alu", {o_asa, o_asb, o_alu}, {2'b00, 2'b10, 4'b0000});
      check("fetch.cause", o_cause, 2'b00);
      @(negedge clk);
      if (r) break;
      if (k == tmo) begin expect_trap(2'b10); stopped = 1'b1; return; end
    end

    drive_ready(1'($urandom_range(0, 1)));
    #1; cyc++;
    check("decode.ctrl", o_ctrl, 8'h00);
    check("decode.alu", {o_asa, o_asb, o_imm, o_alu}, {2'b01, 2'b01, 3'b010, 4'b0000});
    @(negedge clk);
    if (!m_legal(op, f3, f7, bfull)) begin expect_trap(2'b01); stopped = 1'b1; return; end

    drive_ready(1'($urandom_range(0, 1)));
    #1; cyc++;
    check("exec.alu_control", o_alu, m_alu(op, f3, f7));
    check("exec.src_a", o_asa, 2'b10);
    if (br) begin
      tk = m_taken(f3, z, lt, ltu);
      check("exec.br.ctrl", o_ctrl, ctl(0, 0, 0, 0, tk, 0, 1, 0));
      check("exec.br.srcs", {o_asb, o_rs}, 4'b0000);
    end else begin
      check("exec.ctrl", o_ctrl, 8'h00);
      check("exec.src_b", o_asb, (op == 7'h33) ? 2'b00 : 2'b01);
      check("exec.imm", o_imm, st ? 3'b001 : 3'b000);
    end
    @(negedge clk);

    if (ld || st) begin
      for (int k = 0; k < 100; k++) begin
        r = (k >= mw);
        drive_ready(r);
        #1; cyc++;
        check("mem.ctrl", o_ctrl, ctl(ld, st, 1, 0, 0, 0, st && r, 0));
        if (abort_mem && k == 1) begin
          rst = 1'b0;
          #1;
          check("abort.ctrl", o_ctrl, 8'h00);
          @(negedge clk);
          @(negedge clk);
          rst = 1'b1;
          stopped = 1'b1;
          return;
        end
        @(negedge clk);
        if (r) break;
        if (k == tmo) begin expect_trap(2'b10); stopped = 1'b1; return; end
      end
    end

    if (!st && !br) begin
      drive_ready(1'($urandom_range(0, 1)));
      #1; cyc++;
      check("wb.ctrl", o_ctrl, ctl(0, 0, 0, 0, 0, 1, 1, 0));
      check("wb.result_src", o_rs, ld ? 2'b01 : 2'b00);
      @(negedge clk);
    end
    check("cycles", cyc, m_cycles(op, fw, mw));
  endtask

  task automatic random_phase(input int n);
    logic [6:0] ops [6];
    logic [6:0] op, f7;
    int fw, mw;
    bit st;
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
    ops[3] = 7'h23; ops[4] = 7'h63; ops[5] = 7'h6f;
    for (int i = 0; i < n; i++) begin
      op = ops[$urandom_range(0, 5)];
      case ($urandom_range(0, 3))
        0, 1:    f7 = 7'h00;
        2:       f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      fw = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 3);
      mw = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 3);
      run_instr(op, 3'($urandom), f7, 1'($urandom), 1'($urandom), 1'($urandom), fw, mw, 1'b0, st);
      if (st) do_reset();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    drive_ready(1'b1);
    @(negedge clk);
    sel = 0;
    do_reset();

    run_instr(7'h33, 3'd0, 7'h00, 0, 0, 0, 0, 0, 1'b0, st);  // ADD
    run_instr(7'h03, 3'd2, 7'h00, 0, 0, 0, 0, 3, 1'b0, st);  // LW, 3 waits
    run_instr(7'h33, 3'd0, 7'h20, 0, 0, 0, 1, 0, 1'b0, st);  // SUB
    run_instr(7'h33, 3'd7, 7'h00, 0, 0, 0, 0, 0, 1'b0, st);  // AND
    run_instr(7'h13, 3'd5, 7'h20, 0, 0, 0, 0, 0, 1'b0, st);  // SRAI
    run_instr(7'h13, 3'd0, 7'h20, 0, 0, 0, 0, 0, 1'b0, st);  // ADDI, bit forced 0
    run_instr(7'h63, 3'd0, 7'h00, 1, 0, 0, 0, 0, 1'b0, st);  // BEQ taken
    run_instr(7'h63, 3'd4, 7'h00, 0, 0, 0, 0, 0, 1'b0, st);  // BLT not taken
    run_instr(7'h63, 3'd7, 7'h00, 0, 0, 0, 2, 0, 1'b0, st);  // BGEU taken
    run_instr(7'h23, 3'd2, 7'h00, 0, 0, 0, 0, 0, 1'b0, st);  // SW
    run_instr(7'h33, 3'd0, 7'h01, 0, 0, 0, 0, 0, 1'b0, st);  // illegal funct7
    do_reset();
    run_instr(7'h23, 3'd2, 7'h00, 0, 0, 0, 0, 3, 1'b1, st);  // SW aborted by reset
    run_instr(7'h33, 3'd4, 7'h00, 0, 0, 0, 0, 0, 1'b0, st);  // XOR after abort
    run_instr(7'h63, 3'd2, 7'h00, 0, 0, 0, 0, 0, 1'b0, st);  // branch funct3 010
    do_reset();
    random_phase(60);

    sel = 1;
    do_reset();
    run_instr(7'h63, 3'd4, 7'h00, 0, 1, 0, 0, 0, 1'b0, st);  // BLT with BEQ/BNE only
    do_reset();
    run_instr(7'h63, 3'd1, 7'h00, 0, 0, 0, 0, 0, 1'b0, st);  // BNE taken
    run_instr(7'h33, 3'd0, 7'h00, 0, 0, 0, 5, 0, 1'b0, st);  // fetch timeout
    do_reset();
    run_instr(7'h33, 3'd0, 7'h00, 0, 0, 0, 4, 0, 1'b0, st);  // ready in limit cycle
    run_instr(7'h03, 3'd2, 7'h00, 0, 0, 0, 0, 4, 1'b0, st);  // load ready in limit cycle
    run_instr(7'h23, 3'd2, 7'h00, 0, 0, 0, 0, 5, 1'b0, st);  // store timeout
    do_reset();
    random_phase(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multi-cycle control unit for the RV32I core. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over a shared memory port with a ready handshake and variable latency. It drives the datapath mux selects and enables, and decodes ALU operations for R-, I-ALU, load, store and branch instructions. It adds illegal-opcode and memory-timeout traps, and a per-instruction retire pulse.

## Interface
- MEM_TIMEOUT, 16: max wait cycles for mem_ready in FETCH/MEMORY; 0 disables timeout
- BRANCH_FULL, 1: 1 = all six branch conditions; 0 = only BEQ/BNE, other branch funct3 are illegal
- TIMER_W, $clog2(MEM_TIMEOUT+1): wait-counter width (derived)
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- opcode  input  7  instruction register [6:0]
- funct3  input  3  instruction register [14:12]
- funct7  input  7  instruction register [31:25]
- alu_zero / alu_lt / alu_ltu  input  1 each  ALU compare flags (rs1-rs2)
- mem_ready  input  1  memory completes current request this cycle
- mem_re / mem_we  output  1 each  memory read / write request
- addr_src  output  1  0 = PC, 1 = alu_out register
- ir_write / pc_write / regwrite  output  1 each  register enables
- alu_src_a  output  2  00 PC, 01 oldPC, 10 rs1
- alu_src_b  output  2  00 rs2, 01 imm, 10 const 4
- result_src  output  2  00 alu_out reg, 01 mem data, 10 ALU result
- alu_control  output  4  {funct7[5],funct3} encoding (ADD 0000, SUB 1000)
- imm_sel  output  3  I 000, S 001, B 010
- instr_done  output  1  one-cycle retire pulse
- trap  output  1  sticky trap flag
- trap_cause  output  2  00 none, 01 illegal, 10 mem timeout

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
- FETCH: mem_re=1, addr_src=0, alu PC+4 (src_a 00, src_b 10, ADD). On mem_ready: ir_write=1, pc_write=1, go to DECODE.
- DECODE: alu oldPC+imm (src_a 01, src_b 01, imm_sel B, ADD), result latched as branch target.
  - Illegal opcode or funct goes to TRAP, cause 01.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011.
- EXECUTE:
  - R: src_a 10, src_b 00, alu_control={funct7[5],funct3}; funct7 other than 0000000 or 0100000 is illegal; funct7[5]=1 is legal only for funct3 000/101.
  - I-ALU: src_b 01, imm_sel I; funct7[5] honoured only for funct3 101 (SRAI), forced 0 otherwise.
  - LOAD/STORE: rs1+imm (imm_sel I/S), ADD.
  - BRANCH: SUB on rs1,rs2; pc_write=taken, result_src 00 (target); instr_done=1; go to FETCH.
  - Taken conditions: BEQ zero, BNE !zero, BLT lt, BGE !lt, BLTU ltu, BGEU !ltu; funct3 010/011 are illegal.
  - R/I-ALU go to WRITEBACK; LOAD/STORE go to MEMORY.
- MEMORY: addr_src=1, mem_re (load) or mem_we (store) held until mem_ready.
  - Load goes to WRITEBACK.
  - Store: instr_done=1, go to FETCH.
- WRITEBACK: regwrite=1, result_src 00 (ALU ops) or 01 (load), instr_done=1, go to FETCH.
- TRAP: all enables and requests 0; trap=1; cause held; exits only via reset.
- Timeout: wait counter cleared on state entry, increments each FETCH/MEMORY cycle without mem_ready. If the counter equals MEM_TIMEOUT and mem_ready is still 0, go to TRAP with cause 10. mem_ready in that same cycle wins (completes normally).
- In every state, outputs not listed are 0.

## Timing
- Reset (rst=0): state FETCH, counter 0, trap_cause 00. All outputs are forced 0 combinationally while rst=0.
- First fetch request is visible in the first cycle after rst rises.
- Outputs are a combinational function of state, IR fields and flags. All transitions happen on the clk edge.
- Cycles with zero-wait memory (mem_ready high in the request cycle):
  - R/I-ALU 4, load 5, store 4, branch 3.
  - Each wait cycle adds 1.
- instr_done rises in the last cycle of each instruction, never in TRAP.
- mem_re/mem_we stay stable, with addr_src unchanged, from assertion until the mem_ready cycle inclusive.
- Reset mid-instruction aborts immediately; no enable glitches while rst=0.

## Structure
- rv32i_pkg holds:
  - opcode constants
  - alu_ctrl_t enum (4-bit encodings above)
  - imm_sel_t, alu_src_a_t, alu_src_b_t, result_src_t
  - state_t, trap_cause_t
- Sub-module alu_decoder: combinational; opcode class, funct3, funct7 in, alu_control and legal out. It is reused by EXECUTE and DECODE legality.

## Test plan
- ADD (0110011/000/0000000), mem_ready always 1 -> 4 cycles; WRITEBACK regwrite=1 with alu_control 0000; instr_done once.
- LW (0000011/010) with mem_ready delayed 3 cycles in MEMORY -> mem_re held 4 cycles with addr_src=1; WRITEBACK result_src 01; total 8 cycles.
- SUB then AND -> alu_control 1000 then 0111; SUB with funct7 0000001 -> TRAP, cause 01, trap=1 until reset.
- BEQ alu_zero=1 -> pc_write in EXECUTE, 3 cycles. BLT alu_lt=0 -> no pc_write. BLT with BRANCH_FULL=0 -> TRAP cause 01.
- MEM_TIMEOUT=4, mem_ready held 0 in FETCH -> TRAP cause 10 on the 5th wait cycle. Repeat with mem_ready=1 on that cycle -> normal DECODE.
- Drop rst during MEMORY of a store -> mem_we drops immediately. After release, first cycle is FETCH with mem_re=1 and trap_cause 00.
